// File: rtl/data_mem_ctrl.sv
//==============================================================================
// Module      : data_mem_ctrl
// Description : Wait-stated word memory with req/ack handshake and range check.
//               Optional parity protection is enabled with DMEM_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module data_mem_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
`ifdef DMEM_PARITY_EN
    input  logic              par_inject,
    output logic              parity_err,
`endif
    output logic              ready,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      C_WAIT  = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              w_acc_we;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_acc_wdata;
    logic [IDX_W-1:0]  w_idx;
    logic              w_range_ok;
    logic              w_enter_resp;
    logic              w_mem_wr;
    logic [DATA_W-1:0] w_rd_word;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = C_WAIT;
                    state_d = (C_WAIT != 4'd0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        ready = (state_q == S_IDLE);
        ack   = (state_q == S_RESP);
        err   = err_q & (state_q == S_RESP);
        rdata = rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == S_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // With zero wait states the access edge is the accept edge, so the live inputs are used there.
    assign w_acc_we     = (state_q == S_IDLE) ? we    : we_q;
    assign w_acc_addr   = (state_q == S_IDLE) ? addr  : addr_q;
    assign w_acc_wdata  = (state_q == S_IDLE) ? wdata : wdata_q;
    assign w_idx        = w_acc_addr[IDX_W-1:0];
    assign w_range_ok   = ({1'b0, w_acc_addr} < C_DEPTH);
    assign w_enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign w_mem_wr     = w_enter_resp & w_acc_we & w_range_ok & reset_n;
    assign w_rd_word    = mem[w_idx];

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            mem[w_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (w_enter_resp) begin
            err_q <= ~w_range_ok;
            if (!w_acc_we) begin
                rdata_q <= w_range_ok ? w_rd_word : '0;
            end
        end else if (state_q == S_RESP) begin
            err_q <= 1'b0;
        end
    end

`ifdef DMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic pinj_q;
    logic perr_q;
    logic w_acc_pinj;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pinj_q <= 1'b0;
        end else if (state_q == S_IDLE && req) begin
            pinj_q <= par_inject;
        end
    end

    assign w_acc_pinj = (state_q == S_IDLE) ? par_inject : pinj_q;

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            par_mem[w_idx] <= (^w_acc_wdata) ^ w_acc_pinj;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else if (w_enter_resp) begin
            perr_q <= ~w_acc_we & w_range_ok & ((^w_rd_word) != par_mem[w_idx]);
        end else if (state_q == S_RESP) begin
            perr_q <= 1'b0;
        end
    end

    assign parity_err = perr_q & (state_q == S_RESP);
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
//==============================================================================
// Module      : tb_data_mem_ctrl
// Description : Directed self-checking bench for data_mem_ctrl (2 and 0 wait states).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_req, a_we;
    logic [15:0] a_addr, a_wdata;
    logic        a_ready, a_ack, a_err;
    logic [15:0] a_rdata;

    logic        b_req, b_we;
    logic [15:0] b_addr, b_wdata;
    logic        b_ready, b_ack, b_err;
    logic [15:0] b_rdata;

`ifdef DMEM_PARITY_EN
    logic        a_pinj, a_perr, b_pinj, b_perr;
    logic        exp_perr;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] vals [4];

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(2)) u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (a_req),
        .we         (a_we),
        .addr       (a_addr),
        .wdata      (a_wdata),
`ifdef DMEM_PARITY_EN
        .par_inject (a_pinj),
        .parity_err (a_perr),
`endif
        .ready      (a_ready),
        .ack        (a_ack),
        .rdata      (a_rdata),
        .err        (a_err)
    );

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_STATES(0)) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (b_req),
        .we         (b_we),
        .addr       (b_addr),
        .wdata      (b_wdata),
`ifdef DMEM_PARITY_EN
        .par_inject (b_pinj),
        .parity_err (b_perr),
`endif
        .ready      (b_ready),
        .ack        (b_ack),
        .rdata      (b_rdata),
        .err        (b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One access on the 2-wait-state instance; inputs are scrambled after accept.
    task automatic access_a(input logic w, input logic [15:0] ad, input logic [15:0] wd,
                            input logic [15:0] exp_rd, input logic exp_err, input string tag);
        int lat;
        a_req   = 1'b1;
        a_we    = w;
        a_addr  = ad;
        a_wdata = wd;
        step();
        a_req   = 1'b0;
        a_we    = ~w;
        a_addr  = ~ad;
        a_wdata = ~wd;
        chk({tag, "_busy"}, 32'(a_ready), 32'd0);
        lat = 0;
        while (!a_ack && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        chk({tag, "_ready_resp"}, 32'(a_ready), 32'd0);
        chk({tag, "_err"}, 32'(a_err), 32'(exp_err));
        if (!w) chk({tag, "_rdata"}, 32'(a_rdata), 32'(exp_rd));
`ifdef DMEM_PARITY_EN
        if (!w && !exp_err) chk({tag, "_perr"}, 32'(a_perr), 32'(exp_perr));
`endif
        step();
        chk({tag, "_ack_drop"}, 32'(a_ack), 32'd0);
        chk({tag, "_err_drop"}, 32'(a_err), 32'd0);
        chk({tag, "_ready_back"}, 32'(a_ready), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef DMEM_PARITY_EN
        a_pinj = 1'b0; b_pinj = 1'b0; exp_perr = 1'b0;
`endif
        vals[0] = 16'hA001; vals[1] = 16'h5A02; vals[2] = 16'h3C03; vals[3] = 16'hFF04;

        #1;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_ack",   32'(a_ack),   32'd0);
        chk("rst_err",   32'(a_err),   32'd0);
        chk("rst_rdata", 32'(a_rdata), 32'h0000);
`ifdef DMEM_PARITY_EN
        chk("rst_perr",  32'(a_perr),  32'd0);
`endif
        step();
        step();
        reset_n = 1'b1;
        step();

        access_a(1'b1, 16'h0005, 16'h5555, 16'h0000, 1'b0, "wr5");
        access_a(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "wr10");
        access_a(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "rd10");
        access_a(1'b1, 16'h0000, 16'hC0DE, 16'h0000, 1'b0, "wr0");
        chk("rdata_hold_wr", 32'(a_rdata), 32'hBEEF);

        access_a(1'b1, 16'h0100, 16'h1234, 16'h0000, 1'b1, "wr_oor");
        access_a(1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, "rd_oor");
        access_a(1'b0, 16'h0000, 16'h0000, 16'hC0DE, 1'b0, "rd0");

        // Reset asserted mid-cycle while a write is waiting.
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0005; a_wdata = 16'hAAAA;
        step();
        a_req = 1'b0;
        step();
        chk("abort_in_wait", 32'(a_ready), 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(a_ready), 32'd1);
        chk("arst_ack",   32'(a_ack),   32'd0);
        chk("arst_err",   32'(a_err),   32'd0);
        chk("arst_rdata", 32'(a_rdata), 32'h0000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_noack", 32'(a_ack), 32'd0);
        end
        reset_n = 1'b1;
        step();
        access_a(1'b0, 16'h0005, 16'h0000, 16'h5555, 1'b0, "rd5_after_abort");

`ifdef DMEM_PARITY_EN
        a_pinj = 1'b1;
        access_a(1'b1, 16'h0020, 16'h00FF, 16'h0000, 1'b0, "par_wr_inj");
        a_pinj = 1'b0;
        exp_perr = 1'b1;
        access_a(1'b0, 16'h0020, 16'h0000, 16'h00FF, 1'b0, "par_rd_bad");
        exp_perr = 1'b0;
        access_a(1'b1, 16'h0020, 16'h00FF, 16'h0000, 1'b0, "par_wr_ok");
        access_a(1'b0, 16'h0020, 16'h0000, 16'h00FF, 1'b0, "par_rd_ok");
`endif

        // Zero-wait-state instance: preload, then four back-to-back reads with req held.
        b_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_req   = 1'b1;
            b_addr  = 16'(i + 1);
            b_wdata = vals[i];
            step();
            b_req = 1'b0;
            chk("b_wr_ack", 32'(b_ack), 32'd1);
            step();
        end
        b_we  = 1'b0;
        b_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_addr = 16'(i + 1);
            step();
            chk("b2b_ack",   32'(b_ack),   32'd1);
            chk("b2b_ready", 32'(b_ready), 32'd0);
            chk("b2b_rdata", 32'(b_rdata), 32'(vals[i]));
            chk("b2b_err",   32'(b_err),   32'd0);
            step();
            chk("b2b_gap_ack",   32'(b_ack),   32'd0);
            chk("b2b_gap_ready", 32'(b_ready), 32'd1);
        end
        b_req = 1'b0;
        step();
        chk("b_idle_ack", 32'(b_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
